// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path.
// WB_BYPASS_EN adds a forwarding path from the write port to decode.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus: ALU/mem results in, decode queries, register-file write out.
// WB_BYPASS_EN adds bypass_rs1/bypass_rs2/bypass_data.
interface regfile_writeback_arbiter_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] query_rs1;
  logic [REG_ADDR_W-1:0] query_rs2;
  logic [REG_ADDR_W-1:0] query_rd;
  logic                  hazard_rs1;
  logic                  hazard_rs2;
  logic                  hazard_rd;
  logic [REG_ADDR_W-1:0] register_d;
  logic [XLEN-1:0]       data_register_d_in;
  logic                  write_register_d;
`ifdef WB_BYPASS_EN
  logic                  bypass_rs1;
  logic                  bypass_rs2;
  logic [XLEN-1:0]       bypass_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    output query_rs1, query_rs2, query_rd,
    input  alu_ready,
    input  hazard_rs1, hazard_rs2, hazard_rd,
    input  register_d, data_register_d_in,
    input  write_register_d
`ifdef WB_BYPASS_EN
    , input bypass_rs1, bypass_rs2, bypass_data
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    input  query_rs1, query_rs2, query_rd,
    output alu_ready,
    output hazard_rs1, hazard_rs2, hazard_rd,
    output register_d, data_register_d_in,
    output write_register_d
`ifdef WB_BYPASS_EN
    , output bypass_rs1, bypass_rs2, bypass_data
`endif
  );

endinterface

// File: rtl/wb_result_fifo.sv
// In-order ALU result buffer; pointers wrap modulo DEPTH.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t pop_entry,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign pop_entry = mem_q[rd_ptr];

  // Storage carries no reset; count alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= push_entry;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and load results onto the register-file write port.
// WB_BYPASS_EN: forward the in-flight write to decode.
module regfile_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                        clk,
  input logic                        reset,
  regfile_writeback_arbiter_if.slave bus
);

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  wb_entry_t             alu_entry;
  wb_entry_t             head;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic                  wr_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;

  assign bus.alu_ready = !full;
  assign push          = bus.alu_valid && !full;
  assign pop           = !bus.mem_valid && !empty;
  assign alu_entry     = '{rd: bus.alu_rd, data: bus.alu_data};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (alu_entry),
    .pop        (pop),
    .pop_entry  (head),
    .full       (full),
    .empty      (empty)
  );

  // Write port: loads win, otherwise drain the FIFO head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q <= bus.mem_valid || !empty;
      if (bus.mem_valid) begin
        rd_q   <= bus.mem_rd;
        data_q <= bus.mem_data;
      end else if (!empty) begin
        rd_q   <= head.rd;
        data_q <= head.data;
      end
    end
  end

  assign bus.write_register_d   = wr_q;
  assign bus.register_d         = rd_q;
  assign bus.data_register_d_in = data_q;

  // Scoreboard next state; a new issue overrides a retiring write.
  always_comb begin
    pending_nxt = pending;
    if (wr_q) pending_nxt[rd_q] = 1'b0;
    if (bus.issue_valid) pending_nxt[bus.issue_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

`ifdef WB_BYPASS_EN
  logic byp_rs1;
  logic byp_rs2;
  logic byp_rd;

  // Operand matches the write leaving this cycle.
  always_comb begin
    byp_rs1 = wr_q && (rd_q == bus.query_rs1);
    byp_rs2 = wr_q && (rd_q == bus.query_rs2);
    byp_rd  = wr_q && (rd_q == bus.query_rd);
  end

  // Hazards, masked when the value can be forwarded.
  always_comb begin
    bus.hazard_rs1 = pending[bus.query_rs1] &&
      !(byp_rs1 && !(bus.issue_valid && bus.issue_rd == bus.query_rs1));
    bus.hazard_rs2 = pending[bus.query_rs2] &&
      !(byp_rs2 && !(bus.issue_valid && bus.issue_rd == bus.query_rs2));
    bus.hazard_rd  = pending[bus.query_rd] &&
      !(byp_rd && !(bus.issue_valid && bus.issue_rd == bus.query_rd));
  end

  assign bus.bypass_rs1  = byp_rs1;
  assign bus.bypass_rs2  = byp_rs2;
  assign bus.bypass_data = data_q;
`else
  // Hazards straight from the scoreboard.
  always_comb begin
    bus.hazard_rs1 = pending[bus.query_rs1];
    bus.hazard_rs2 = pending[bus.query_rs2];
    bus.hazard_rd  = pending[bus.query_rd];
  end
`endif

  // Decode may only reissue a pending rd on the edge that retires it.
  a_no_waw_issue: assert property (
    @(posedge clk) disable iff (reset)
    bus.issue_valid |->
      (!pending[bus.issue_rd] || (wr_q && rd_q == bus.issue_rd))
  );

endmodule
